toeplitz_colgen: RTL and testbench
==================================

TOEPLITZ_COLGEN -- requirements
Module: toeplitz_colgen

Interface
REQ-001 SHALL have parameter BS, default 64: seed block width in bits; N and L SHALL be integer multiples of BS.
REQ-002 SHALL have parameter N, default 256: number of Toeplitz columns, equal to input bits per output block.
REQ-003 SHALL have parameter L, default 128: column length, equal to output bits per block.
REQ-004 SHALL have parameter WIDTH, default 2: columns produced per cycle; N SHALL be a multiple of WIDTH.
REQ-005 SHALL have parameter ROW_SEED [N-1:0], default the package row-seed constant: first matrix row.
REQ-006 SHALL have parameter COL_SEED [L-1:0], default the package column-seed constant: first matrix column.
REQ-007 clk  input  1  rising-edge clock, the only clock.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 en  input  1  advance the columns by WIDTH on this clock edge.
REQ-010 col  output  WIDTH*L  lane k at bits [k*L +: L] carries matrix column c+k.
REQ-011 last  output  1  high while the lanes carry columns N-WIDTH .. N-1.

Function
REQ-012 Matrix element T[i][j], with i in 0..L-1 and j in 0..N-1, SHALL equal COL_SEED[i-j] when i>=j, else ROW_SEED[j-i].
REQ-013 ROW_SEED[0] SHALL equal COL_SEED[0]; a mismatch SHALL be flagged by an elaboration-time assertion.
REQ-014 Lane k bit i SHALL equal T[i][c+k], where c is the internal column base; c is a multiple of WIDTH in 0..N-WIDTH.
REQ-015 On a clk edge with en=1, c SHALL become c+WIDTH; when c=N-WIDTH it SHALL wrap to 0.
REQ-016 On a clk edge with en=0, c and col SHALL hold.
REQ-017 Each lane SHALL advance by an incremental register update, not a lookup: new bit i = old bit i-WIDTH for i>=WIDTH, and new bit i = ROW_SEED[c+k+WIDTH-i] for i<WIDTH.
REQ-018 On wrap, each lane SHALL be reloaded with its column-k value.
REQ-019 col SHALL be a registered output with zero combinational path from en.
REQ-020 last SHALL be 1 exactly when c=N-WIDTH.
REQ-021 One full pass SHALL take N/WIDTH enabled cycles.

Reset
REQ-022 While reset=1, and immediately on its assertion, c SHALL be 0.
REQ-023 While reset=1, lane k SHALL hold column k: bit i = T[i][k].
REQ-024 While reset=1, last SHALL be 1 if N=WIDTH, else 0.
REQ-025 Reset asserted mid-pass SHALL abandon the pass; the first enabled edge after release SHALL present columns WIDTH..2*WIDTH-1.

Structure
REQ-026 A shared package SHALL hold the default row and column seed constants, stored as N/BS and L/BS words of BS bits.
REQ-027 The shared package SHALL hold a helper returning T[i][j] for the bench's reference model.
REQ-028 Sub-module readrc SHALL assemble the seed words into flat vectors rrow0[N-1:0] and col0[L-1:0]; it SHALL be purely combinational with no ports besides these.
REQ-029 The lane update logic SHALL be a generate loop over WIDTH inside toeplitz_colgen.

Verification
All scenarios use N=8, L=4, WIDTH=2, BS=4, ROW_SEED=8'b10010111, COL_SEED=4'b0011.
REQ-030 Reset:
- hold reset=1 -> lane0=4'b0011, lane1=4'b0111, last=0.
REQ-031 Stepping:
- release reset, en=1 for one edge -> lane0=4'b1111, lane1=4'b1110.
- further edges -> the lanes step through columns 4/5, then 6/7.
- on columns 6/7, last=1.
REQ-032 Wrap:
- after the 4th enabled edge -> lanes return to 4'b0011 and 4'b0111, and last=0.
REQ-033 Hold:
- en=0 for 3 edges mid-pass -> col and last unchanged.
- the next en=1 edge resumes at the next column pair.
REQ-034 Async reset:
- pulse reset between clk edges while on columns 4/5 -> col shows columns 0/1 before the next edge.
REQ-035 Defaults and checks:
- default parameters, random en -> every lane matches the package helper model each cycle.
- after exactly N/WIDTH=128 enabled edges, state equals the reset state.

Source files
------------

// File: rtl/toeplitz_colgen_pkg.sv
// Shared definitions for the Toeplitz column generator.
//   - Default row/column seeds, stored as BS-bit words (word 0 = least
//     significant bits), plus the same seeds flattened into vectors.
//   - t_elem(): reference helper returning matrix element T[i][j].
package toeplitz_colgen_pkg;

  localparam int DEF_BS    = 64;
  localparam int ROW_MAX   = 256;
  localparam int COL_MAX   = 128;
  localparam int ROW_WORDS = ROW_MAX / DEF_BS;
  localparam int COL_WORDS = COL_MAX / DEF_BS;

  // Bit 0 of row word 0 and bit 0 of column word 0 are both 1; they are the
  // same matrix element T[0][0].
  localparam logic [DEF_BS-1:0] ROW_SEED_WORDS [ROW_WORDS] = '{
    64'hA5C3_9E17_4B2D_F081,
    64'h3C6E_91D4_7A05_B2EF,
    64'hD1F2_0C8B_6E39_45A7,
    64'h5B8E_C4A1_2F73_9D61
  };

  localparam logic [DEF_BS-1:0] COL_SEED_WORDS [COL_WORDS] = '{
    64'h7E21_D39C_05AB_48F3,
    64'hC92F_6B14_E087_3D5A
  };

  localparam logic [ROW_MAX-1:0] DEF_ROW_SEED = {ROW_SEED_WORDS[3], ROW_SEED_WORDS[2],
                                                 ROW_SEED_WORDS[1], ROW_SEED_WORDS[0]};
  localparam logic [COL_MAX-1:0] DEF_COL_SEED = {COL_SEED_WORDS[1], COL_SEED_WORDS[0]};

  // T[i][j] = col[i-j] on/below the diagonal, row[j-i] above it.
  function automatic logic t_elem(input logic [ROW_MAX-1:0] row,
                                  input logic [COL_MAX-1:0] colv,
                                  input int i, input int j);
    logic [ROW_MAX-1:0] r_sh;
    logic [COL_MAX-1:0] c_sh;
    r_sh = row >> (j - i);
    c_sh = colv >> (i - j);
    return (i >= j) ? c_sh[0] : r_sh[0];
  endfunction

endpackage

// File: rtl/toeplitz_colgen_readrc.sv
// Seed assembly: splits the row and column seeds into BS-bit words and
// reassembles them into the flat vectors used by the column generator.
// Purely combinational.
// Ports:
//   rrow0 [N-1:0]  output  first matrix row    (bit j = T[0][j])
//   col0  [L-1:0]  output  first matrix column (bit i = T[i][0])
module toeplitz_colgen_readrc #(
  parameter int             BS       = 64,
  parameter int             N        = 256,
  parameter int             L        = 128,
  parameter logic [N-1:0]   ROW_SEED = '0,
  parameter logic [L-1:0]   COL_SEED = '0
) (
  output logic [N-1:0] rrow0,
  output logic [L-1:0] col0
);

  logic [BS-1:0] row_words [N/BS];
  logic [BS-1:0] col_words [L/BS];

  genvar gi;
  generate
    for (gi = 0; gi < N/BS; gi++) begin : g_row
      assign row_words[gi]          = ROW_SEED[gi*BS +: BS];
      assign rrow0[gi*BS +: BS]     = row_words[gi];
    end
    for (gi = 0; gi < L/BS; gi++) begin : g_col
      assign col_words[gi]          = COL_SEED[gi*BS +: BS];
      assign col0[gi*BS +: BS]      = col_words[gi];
    end
  endgenerate

endmodule

// File: rtl/toeplitz_colgen.sv
// Toeplitz matrix column generator. Presents WIDTH consecutive columns of an
// L x N Toeplitz matrix per cycle and advances by WIDTH columns on each
// enabled clock edge, wrapping after column N-1.
// Ports:
//   clk    input               rising-edge clock
//   reset  input               asynchronous active-high reset
//   en     input               advance the columns by WIDTH
//   col    output [WIDTH*L-1:0] lane k at [k*L +: L] = column c+k (registered)
//   last   output              high while lanes carry columns N-WIDTH..N-1
module toeplitz_colgen
  import toeplitz_colgen_pkg::*;
#(
  parameter int           BS       = 64,
  parameter int           N        = 256,
  parameter int           L        = 128,
  parameter int           WIDTH    = 2,
  parameter logic [N-1:0] ROW_SEED = N'(DEF_ROW_SEED),
  parameter logic [L-1:0] COL_SEED = L'(DEF_COL_SEED)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic [WIDTH*L-1:0]   col,
  output logic                 last
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(N - WIDTH);
  localparam logic [CW-1:0] STEP_C = CW'(WIDTH);

  // Parameter sanity, caught at elaboration.
  generate
    if (ROW_SEED[0] != COL_SEED[0]) begin : g_chk_seed
      $error("toeplitz_colgen: ROW_SEED[0] and COL_SEED[0] must match");
    end
    if ((N % BS) != 0 || (L % BS) != 0) begin : g_chk_bs
      $error("toeplitz_colgen: N and L must be multiples of BS");
    end
    if ((N % WIDTH) != 0 || N < 2) begin : g_chk_w
      $error("toeplitz_colgen: N must be a multiple of WIDTH and at least 2");
    end
  endgenerate

  logic [N-1:0] rrow0;
  logic [L-1:0] col0;

  toeplitz_colgen_readrc #(
    .BS       (BS),
    .N        (N),
    .L        (L),
    .ROW_SEED (ROW_SEED),
    .COL_SEED (COL_SEED)
  ) u_readrc (
    .rrow0 (rrow0),
    .col0  (col0)
  );

  logic [CW-1:0]        c_q, c_d;
  logic [WIDTH*L-1:0]   col_q, col_d;
  logic [WIDTH*L-1:0]   init_vec;   // columns 0..WIDTH-1
  logic [WIDTH*L-1:0]   step_vec;   // each lane advanced by WIDTH columns
  logic                 wrap;

  assign wrap = (c_q == LAST_C);

  genvar gi, gb;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      for (gb = 0; gb < L; gb++) begin : g_bit
        // Reload value: T[gb][gi].
        if (gb >= gi) begin : g_init_col
          assign init_vec[gi*L + gb] = col0[gb - gi];
        end else begin : g_init_row
          assign init_vec[gi*L + gb] = rrow0[gi - gb];
        end

        // Moving WIDTH columns right along a Toeplitz matrix is a downward
        // shift by WIDTH rows; the top WIDTH rows enter from the first row.
        if (gb >= WIDTH) begin : g_shift
          assign step_vec[gi*L + gb] = col_q[gi*L + gb - WIDTH];
        end else begin : g_enter
          logic [CW-1:0] idx;
          // Index wraps harmlessly on the wrap edge, where step_vec is unused.
          assign idx = c_q + CW'(gi + WIDTH - gb);
          assign step_vec[gi*L + gb] = rrow0[idx];
        end
      end
    end
  endgenerate

  always_comb begin
    c_d   = c_q + STEP_C;
    col_d = step_vec;
    if (wrap) begin
      c_d   = '0;
      col_d = init_vec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q   <= '0;
      col_q <= init_vec;
    end else if (en) begin
      c_q   <= c_d;
      col_q <= col_d;
    end
  end

  assign col  = col_q;
  assign last = (c_q == LAST_C);

endmodule

// File: tb/tb_toeplitz_colgen.sv
module tb_toeplitz_colgen;
  import toeplitz_colgen_pkg::*;

  // Small directed instance: N=8, L=4, WIDTH=2, BS=4.
  logic       clk = 1'b0;
  logic       reset, en;
  logic [7:0] col;
  logic       last;

  // Default-parameter instance.
  localparam int DN = 256, DL = 128, DW = 2;
  logic                reset_b, en_b;
  logic [DW*DL-1:0]    col_b;
  logic                last_b;

  always #5 clk = ~clk;

  toeplitz_colgen #(
    .BS(4), .N(8), .L(4), .WIDTH(2),
    .ROW_SEED(8'b10010111), .COL_SEED(4'b0011)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .col(col), .last(last)
  );

  toeplitz_colgen dut_def (
    .clk(clk), .reset(reset_b), .en(en_b), .col(col_b), .last(last_b)
  );

  int tests = 0;
  int fails = 0;

  // Hand-computed {lane1, lane0} for column pairs 0/1, 2/3, 4/5, 6/7.
  logic [7:0] pairs [4] = '{8'b0111_0011, 8'b1110_1111, 8'b1010_1101, 8'b1001_0100};

  typedef struct {
    logic [7:0] col;
    logic       last;
    string      name;
  } exp_t;

  typedef struct {
    logic [DW*DL-1:0] col;
    logic             last;
    int               cnum;
  } exp_def_t;

  exp_t     sb[$];
  exp_def_t sb_def[$];
  event     chk_ev;

  function automatic logic [DW*DL-1:0] def_vec(input int c);
    logic [DW*DL-1:0] v;
    for (int k = 0; k < DW; k++)
      for (int i = 0; i < DL; i++)
        v[k*DL + i] = t_elem(DEF_ROW_SEED, DEF_COL_SEED, i, c + k);
    return v;
  endfunction

  // Monitor for the directed instance: one expectation per trigger.
  initial begin : mon_small
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (col !== e.col || last !== e.last) begin
          fails++;
          $display("FAIL %s: col=%b last=%b, expected col=%b last=%b",
                   e.name, col, last, e.col, e.last);
        end else begin
          $display("[TB] ok %s col=%b last=%b", e.name, col, last);
        end
      end
    end
  end

  // Monitor for the default instance.
  initial begin : mon_def
    exp_def_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_def.size() > 0) begin
        e = sb_def.pop_front();
        tests++;
        if (col_b !== e.col || last_b !== e.last) begin
          fails++;
          $display("FAIL def_c%0d: col=%h last=%b, expected col=%h last=%b",
                   e.cnum, col_b, last_b, e.col, e.last);
        end else begin
          $display("[TB] ok def_c%0d last=%b", e.cnum, last_b);
        end
      end
    end
  end

  // Expect pair p after the next clock edge with the given en.
  task automatic step(input logic en_val, input int p, input string nm);
    exp_t e;
    en = en_val;
    e.col = pairs[p]; e.last = (p == 3); e.name = nm;
    sb.push_back(e);
    @(posedge clk); #2;
  endtask

  initial begin : stim
    exp_t     e;
    exp_def_t d;
    int       c_model, enabled, cyc;

    reset = 1'b1; en = 1'b0;
    reset_b = 1'b1; en_b = 1'b0;

    // Reset hold.
    step(1'b0, 0, "reset_hold_a");
    step(1'b1, 0, "reset_hold_en");

    // Stepping and wrap.
    reset = 1'b0;
    step(1'b1, 1, "step_c2");
    step(1'b1, 2, "step_c4");
    step(1'b1, 3, "step_c6_last");
    step(1'b1, 0, "wrap_c0");

    // Hold mid-pass.
    step(1'b1, 1, "pre_hold_c2");
    step(1'b0, 1, "hold_1");
    step(1'b0, 1, "hold_2");
    step(1'b0, 1, "hold_3");
    step(1'b1, 2, "resume_c4");

    // Async reset pulse between edges while on columns 4/5.
    en = 1'b0;
    #1;
    reset = 1'b1;
    e.col = pairs[0]; e.last = 1'b0; e.name = "async_rst";
    sb.push_back(e);
    -> chk_ev;
    #3;
    reset = 1'b0;
    step(1'b1, 1, "after_rst_c2");
    step(1'b1, 2, "after_rst_c4");
    step(1'b1, 3, "after_rst_c6");
    step(1'b1, 0, "after_rst_wrap");

    // Default instance: reset state, then random en for a full pass.
    d.col = def_vec(0); d.last = 1'b0; d.cnum = 0;
    sb_def.push_back(d);
    @(posedge clk); #2;
    reset_b = 1'b0;
    c_model = 0; enabled = 0; cyc = 0;
    while (enabled < DN/DW && cyc < 2000) begin
      en_b = 1'($urandom_range(0, 1));
      if (en_b) begin
        enabled++;
        c_model = (c_model == DN - DW) ? 0 : c_model + DW;
      end
      d.col = def_vec(c_model); d.last = (c_model == DN - DW); d.cnum = c_model;
      sb_def.push_back(d);
      cyc++;
      @(posedge clk); #2;
    end
    en_b = 1'b0;
    if (enabled < DN/DW) begin
      tests++; fails++;
      $display("FAIL def_budget: enabled=%0d, required=%0d", enabled, DN/DW);
    end
    // Full pass returns to the reset state.
    tests++;
    if (col_b !== def_vec(0) || last_b !== 1'b0) begin
      fails++;
      $display("FAIL def_full_pass: col=%h last=%b, expected col=%h last=0",
               col_b, last_b, def_vec(0));
    end else begin
      $display("[TB] ok def_full_pass back at columns 0/1");
    end

    @(posedge clk); #3;
    tests++;
    if (sb.size() != 0 || sb_def.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: pending=%0d/%0d, required=0/0", sb.size(), sb_def.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
